// File: rtl/minions_pio_pkg.sv
// Shared constants for the Minions PIO input block: register map, edge-type
// encodings and the Avalon data bus width.
package minions_pio_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/minions_pio_in_if.sv
// Avalon-MM slave bus bundle for the PIO input block (2-bit word address,
// 32-bit data, read latency 0, level interrupt).
interface minions_pio_in_if;
  import minions_pio_pkg::*;

  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/minions_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input vector followed by a
// per-bit edge detector; reusable by other input-capture blocks.
module minions_sync_edge
  import minions_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;

  always_comb begin
    sync_d[0] = async_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Unknown EDGE_TYPE values fall back to rising-edge detection.
  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISING:  edge_pulse = sync_in & ~prev_q;
      EDGE_FALLING: edge_pulse = ~sync_in & prev_q;
      EDGE_ANY:     edge_pulse = sync_in ^ prev_q;
      default:      edge_pulse = sync_in & ~prev_q;
    endcase
  end

endmodule

// File: rtl/minions_pio_in.sv
// Avalon-MM general-purpose input port: synchronized data read, sticky
// write-1-to-clear edge capture and a maskable level interrupt.
module minions_pio_in
  import minions_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic                   clk,
  input  logic                   reset,
  minions_pio_in_if.slave        bus,
  input  logic [WIDTH-1:0]       in_port
);

  logic [WIDTH-1:0]  sync_in;
  logic [WIDTH-1:0]  edge_pulse;
  logic [WIDTH-1:0]  irqmask_q, irqmask_d;
  logic [WIDTH-1:0]  edgecap_q, edgecap_d;
  logic              wr_en;
  logic [DATA_W-1:0] rdata;
  logic              wdata_unused;

  minions_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk        (clk),
    .reset      (reset),
    .async_in   (in_port),
    .sync_in    (sync_in),
    .edge_pulse (edge_pulse)
  );

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wdata_unused = ^bus.writedata;

  // Edge set is applied after the clear so a same-cycle edge always wins.
  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_en && (bus.address == ADDR_IRQMASK)) begin
      irqmask_d = bus.writedata[WIDTH-1:0];
    end else begin
      irqmask_d = irqmask_q;
    end
    if (wr_en && (bus.address == ADDR_EDGECAP)) begin
      edgecap_d = edgecap_q & ~bus.writedata[WIDTH-1:0];
    end else begin
      edgecap_d = edgecap_q;
    end
    edgecap_d = edgecap_d | edge_pulse;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (pio_addr_e'(bus.address))
      ADDR_DATA:    rdata[WIDTH-1:0] = sync_in;
      ADDR_IRQMASK: rdata[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: rdata[WIDTH-1:0] = edgecap_q;
      default:      rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign bus.irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_minions_pio_in.sv
// Directed scoreboard bench for minions_pio_in: one rising-edge instance and
// one any-edge instance sharing a clock.
module tb_minions_pio_in;
  import minions_pio_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in0;
  logic [7:0] in1;
  sb_t        sb_q[$];
  int         errors = 0;
  int         checks = 0;

  minions_pio_in_if bus0();
  minions_pio_in_if bus1();

  minions_pio_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISING)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .in_port(in0)
  );

  minions_pio_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .in_port(in1)
  );

  always #5 clk = ~clk;

  task automatic sb_push(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed %h with no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.address = 2'd0; bus0.writedata = 32'd0;
    bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.address = 2'd0; bus1.writedata = 32'd0;
  endtask

  // Drive a write (or a chipselect-low write when cs=0) for one clock edge.
  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v, input logic cs);
    if (d == 0) begin
      bus0.chipselect = cs; bus0.write_n = 1'b0; bus0.address = a; bus0.writedata = v;
    end else begin
      bus1.chipselect = cs; bus1.write_n = 1'b0; bus1.address = a; bus1.writedata = v;
    end
    tick(1);
    bus_idle();
  endtask

  task automatic peek(input int d, input logic [1:0] a, input string tag, input logic [31:0] exp);
    sb_push(tag, exp);
    if (d == 0) bus0.address = a;
    else bus1.address = a;
    #1;
    sb_check((d == 0) ? bus0.readdata : bus1.readdata);
  endtask

  task automatic chk_irq(input int d, input string tag, input logic exp);
    sb_push(tag, {31'd0, exp});
    sb_check({31'd0, ((d == 0) ? bus0.irq : bus1.irq)});
  endtask

  initial begin
    reset = 1'b1;
    in0   = 8'h00;
    in1   = 8'h00;
    bus_idle();
    tick(3);
    reset = 1'b0;
    peek(0, 2'd0, "rst_data", 32'h0);
    peek(0, 2'd1, "rst_rsvd", 32'h0);
    peek(0, 2'd2, "rst_mask", 32'h0);
    peek(0, 2'd3, "rst_cap", 32'h0);
    chk_irq(0, "rst_irq", 1'b0);

    // Build up state, then reset for one clock mid-operation.
    in0 = 8'h01;
    tick(3);
    peek(0, 2'd3, "pre_rst_cap", 32'h01);
    wr(0, 2'd2, 32'hFF, 1'b1);
    chk_irq(0, "pre_rst_irq", 1'b1);
    in0 = 8'h00;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_irq(0, "mid_rst_irq", 1'b0);
    peek(0, 2'd0, "mid_rst_data", 32'h0);
    peek(0, 2'd1, "mid_rst_rsvd", 32'h0);
    peek(0, 2'd2, "mid_rst_mask", 32'h0);
    peek(0, 2'd3, "mid_rst_cap", 32'h0);

    // Data register read and write-ignore.
    in0 = 8'hA5;
    tick(2);
    peek(0, 2'd0, "data_a5", 32'h000000A5);
    wr(0, 2'd0, 32'hFF, 1'b1);
    peek(0, 2'd0, "data_ro", 32'h000000A5);
    wr(0, 2'd1, 32'hFFFFFFFF, 1'b1);
    peek(0, 2'd1, "rsvd_zero", 32'h0);
    wr(0, 2'd3, 32'hFF, 1'b1);
    peek(0, 2'd3, "cap_cleared", 32'h0);
    in0 = 8'h00;
    tick(4);
    peek(0, 2'd3, "no_fall_cap", 32'h0);

    // Rising capture latency is exactly three clocks.
    in0 = 8'h08;
    tick(2);
    peek(0, 2'd3, "cap_early", 32'h0);
    tick(1);
    peek(0, 2'd3, "cap_lat3", 32'h08);
    in0 = 8'h00;
    tick(4);
    peek(0, 2'd3, "cap_sticky", 32'h08);

    // Interrupt masking.
    chk_irq(0, "irq_masked", 1'b0);
    wr(0, 2'd2, 32'h08, 1'b1);
    chk_irq(0, "irq_unmask", 1'b1);
    peek(0, 2'd2, "mask_rb", 32'h08);
    wr(0, 2'd3, 32'h08, 1'b1);
    chk_irq(0, "irq_clear", 1'b0);
    peek(0, 2'd3, "cap_w1c", 32'h0);

    // Partial clear, upper mask bits dropped, chipselect-low writes ignored.
    in0 = 8'h05;
    tick(3);
    peek(0, 2'd3, "cap_05", 32'h05);
    wr(0, 2'd3, 32'h04, 1'b1);
    peek(0, 2'd3, "cap_partial", 32'h01);
    wr(0, 2'd2, 32'hFFFFFF81, 1'b1);
    peek(0, 2'd2, "mask_trunc", 32'h81);
    chk_irq(0, "irq_bit0", 1'b1);
    wr(0, 2'd3, 32'hFF, 1'b0);
    peek(0, 2'd3, "cs_low_cap", 32'h01);
    wr(0, 2'd2, 32'h00, 1'b0);
    peek(0, 2'd2, "cs_low_mask", 32'h81);

    // Edge and clear on bit0 in the same clock: the edge wins.
    in0 = 8'h04;
    tick(3);
    wr(0, 2'd3, 32'hFF, 1'b1);
    peek(0, 2'd3, "pre_coll_cap", 32'h0);
    chk_irq(0, "pre_coll_irq", 1'b0);
    in0 = 8'h05;
    tick(2);
    wr(0, 2'd3, 32'h01, 1'b1);
    peek(0, 2'd3, "coll_rise", 32'h01);

    // Any-edge instance.
    in1 = 8'h80;
    tick(3);
    peek(1, 2'd3, "any_rise", 32'h80);
    in1 = 8'h00;
    tick(3);
    peek(1, 2'd3, "any_sticky", 32'h80);
    wr(1, 2'd3, 32'h80, 1'b1);
    peek(1, 2'd3, "any_clr", 32'h0);
    in1 = 8'h01;
    tick(2);
    wr(1, 2'd3, 32'h01, 1'b1);
    peek(1, 2'd3, "coll_any", 32'h01);
    wr(1, 2'd3, 32'h01, 1'b1);
    peek(1, 2'd3, "any_clr2", 32'h0);
    in1 = 8'h00;
    tick(3);
    peek(1, 2'd3, "any_fall", 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
